csa_resolver: RTL and testbench
===============================

# csa_resolver

Converts a carry-save pair (partial_sum, saved_carrys) from the 3:2 compressor stage into a single binary word, sum = partial_sum + (saved_carrys << 1) mod 2^WIDTH. It uses a chunked, multi-cycle carry-propagate adder that resolves CHUNK bits per clock. The block sits downstream of the carry_save_adder trees in the SHA-256 round datapath, where T1/T2 and message-schedule sums leave carry-save form. It has valid/ready handshakes on both sides, so the round controller can stall it.

## Interface
Parameters:
- WIDTH, 32, operand and result width; modulo base is 2^WIDTH
- CHUNK, 8, bits resolved per ADD cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 are required, and a violation is an elaboration error

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept the operand pair
- partial_sum  in  WIDTH  carry-save sum vector
- saved_carrys  in  WIDTH  carry-save carry vector, weight 2^(i+1) for bit i
- out_valid  out  1  sum valid
- out_ready  in  1  consumer accepts sum
- sum  out  WIDTH  resolved result

Clocking and reset: one clock; reset is asynchronous and active-low.

## Operation
- Number of chunks: N = WIDTH/CHUNK.
- State machine:
  - IDLE -> ADD on in_valid && in_ready.
  - ADD -> ADD while idx < N-1.
  - ADD -> DONE when idx == N-1.
  - DONE -> IDLE on out_ready && !in_valid.
  - DONE -> ADD on out_ready && in_valid (back-to-back accept).
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from state and out_ready.
- On accept, the block latches:
  - A = partial_sum
  - B = {saved_carrys[WIDTH-2:0], 1'b0}. saved_carrys[WIDTH-1] is discarded by the mod 2^WIDTH rule.
  - carry = 0, idx = 0.
- Each ADD cycle adds chunk idx of A, chunk idx of B and carry. The result is written to the sum register chunk idx, the chunk carry-out goes to carry, and idx increments. The final carry-out of chunk N-1 is discarded.
- Inputs are sampled only at accept; changes to partial_sum/saved_carrys afterwards have no effect.
- out_valid = (state==DONE). sum and out_valid are held stable while out_valid && !out_ready.
- sum register bits are undefined-to-consumer during ADD and are valid only with out_valid.
- Reset values:
  - state IDLE, out_valid 0, sum 0, idx 0, carry 0.
  - in_ready reads 1 while in reset (state IDLE); no handshake completes while rst_n is low.
- Reset mid-ADD or mid-DONE aborts the operation immediately, and the result is lost. The first accept after reset release produces a correct result.

## Timing
- The accept edge is edge 0. ADD occupies edges 1..N.
- out_valid rises after edge N, so latency is N cycles from the accept edge (4 for defaults).
- Throughput is one result per N+1 cycles with out_ready held high (accept in the DONE cycle).
- No combinational path from partial_sum/saved_carrys to sum.
- The only comb path to an output is out_ready -> in_ready.

## Structure
- Shared package/header sha256_pkg: WORD_WIDTH=32, default CHUNK=8, and the state encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) as localparams.
- Sub-module csa_chunk_adder #(CHUNK): combinational CHUNK-bit ripple adder (a, b, c_in -> s, c_out) built from full_adder instances. It is instantiated once; the chunk select uses idx-based part-select on A/B.
- Top: FSM, A/B/sum registers, idx counter of width clog2(N) (minimum 1), carry flop.

## Test plan
- Carry-save chain check: a=1, b=2, c=3 through carry_save_adder gives ps=0x0, sc=0x3; this block then gives sum=0x00000006, out_valid exactly 4 cycles after accept.
- Full ripple and wrap: ps=0xFFFFFFFF, sc=0x00000001 -> sum=0x00000001. This exercises carry across all 4 chunks and the dropped final carry-out.
- MSB discard: ps=0x00000000, sc=0x80000000 -> sum=0x00000000. Also ps=0x00000001, sc=0x7FFFFFFF -> sum=0xFFFFFFFF.
- Backpressure: out_ready low for 5 cycles after out_valid -> sum and out_valid stable, in_ready=0, and a concurrent in_valid is not accepted. Raise out_ready -> exactly one output handshake.
- Back-to-back: in_valid and out_ready held high with 3 operand pairs -> accepts every 5 cycles, no lost or duplicated results. Results match the reference model for random vectors.
- Reset mid-ADD: assert rst_n low after 2 ADD cycles -> out_valid=0, sum=0 asynchronously, state IDLE. After release, ps=0x12345678, sc=0x00000001 -> sum=0x1234567A.

Source files
------------

// File: rtl/sha256_pkg.sv
// ============================================================================
// Module      : sha256_pkg
// Description : Shared widths and FSM state encodings for the SHA-256 datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

    localparam int c_word_width    = 32;
    localparam int c_default_chunk = 8;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_add  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

endpackage : sha256_pkg

`default_nettype wire

// File: rtl/csa_chunk_adder.sv
// ============================================================================
// Module      : csa_chunk_adder (with leaf full_adder)
// Description : Combinational CHUNK-bit ripple adder built from full adders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule : full_adder

module csa_chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = c_in;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
        full_adder u_fa (
            .a     (a[gi]),
            .b     (b[gi]),
            .c_in  (w_c[gi]),
            .s     (s[gi]),
            .c_out (w_c[gi+1])
        );
    end

    assign c_out = w_c[CHUNK];

endmodule : csa_chunk_adder

`default_nettype wire

// File: rtl/csa_resolver.sv
// ============================================================================
// Module      : csa_resolver
// Description : Resolves a carry-save pair into a binary word, CHUNK bits/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_resolver
    import sha256_pkg::*;
#(
    parameter int WIDTH = c_word_width,
    parameter int CHUNK = c_default_chunk
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] partial_sum,
    input  logic [WIDTH-1:0] saved_carrys,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum
);

    localparam int c_n     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int c_idx_w = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_n - 1);

    if (CHUNK < 1) begin : g_chunk_zero
        $error("csa_resolver: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_chunk_mismatch
        $error("csa_resolver: WIDTH must be a multiple of CHUNK");
    end

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [c_idx_w-1:0] r_idx;
    logic               r_out_valid;

    logic               w_accept;
    logic [CHUNK-1:0]   w_chunk_a;
    logic [CHUNK-1:0]   w_chunk_b;
    logic [CHUNK-1:0]   w_chunk_s;
    logic               w_chunk_c;
    logic [WIDTH-1:0]   w_b_shifted;
    logic               w_unused_msb;

    assign in_ready  = (r_state == c_st_idle) || ((r_state == c_st_done) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;

    // Carry weight is 2^(i+1): the top carry bit falls outside mod 2^WIDTH.
    assign w_b_shifted  = {saved_carrys[WIDTH-2:0], 1'b0};
    assign w_unused_msb = saved_carrys[WIDTH-1];

    assign w_chunk_a = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_chunk_b = r_b[int'(r_idx) * CHUNK +: CHUNK];

    csa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a     (w_chunk_a),
        .b     (w_chunk_b),
        .c_in  (r_carry),
        .s     (w_chunk_s),
        .c_out (w_chunk_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_a     <= partial_sum;
                        r_b     <= w_b_shifted;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_state <= c_st_add;
                    end
                end
                c_st_add: begin
                    r_sum[int'(r_idx) * CHUNK +: CHUNK] <= w_chunk_s;
                    r_carry <= w_chunk_c;
                    if (r_idx == c_last_idx) begin
                        r_idx       <= '0;
                        r_state     <= c_st_done;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_st_done: begin
                    // Hold result until the consumer takes it; reload straight away if a pair waits.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_a     <= partial_sum;
                            r_b     <= w_b_shifted;
                            r_carry <= 1'b0;
                            r_idx   <= '0;
                            r_state <= c_st_add;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : csa_resolver

`default_nettype wire

// File: tb/tb_csa_resolver.sv
// ============================================================================
// Module      : tb_csa_resolver
// Description : Scoreboard bench for csa_resolver with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_resolver;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] ps = '0;
    logic [W-1:0] sc = '0;
    logic [W-1:0] cur_exp = '0;
    wire          in_ready;
    wire          out_valid;
    wire  [W-1:0] sum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    logic         prev_ov = 1'b0;

    csa_resolver #(.WIDTH(W), .CHUNK(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .partial_sum  (ps),
        .saved_carrys (sc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sum          (sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Accept observer: a handshake seen at a negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            acc_q.push_back(cyc + 1);
            last_acc = cyc + 1;
        end
    end

    // Output monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        int a;
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL latency: out_valid rose with no accept pending");
                end else begin
                    a = acc_q.pop_front();
                    chk("latency", W'(cyc - a), W'(4));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_hs: unexpected output sum=%h", sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", sum, e);
                end
            end
        end
        prev_ov = out_valid;
    end

    // Caller is at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic send(input logic [W-1:0] p, input logic [W-1:0] c,
                        input logic [W-1:0] e, input bit hold);
        bit ok;
        ok = 1'b0;
        ps = p; sc = c; cur_exp = e; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready %0d required 1", in_ready);
        end
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL drain_timeout: pending %0d required 0", exp_q.size());
        end
    endtask

    initial begin
        int a0;
        int a1;
        // Reset state
        #12;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_sum", sum, '0);
        chk("rst_in_ready", W'(in_ready), W'(1));
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        send(32'h0000_0000, 32'h0000_0003, 32'h0000_0006, 0); drain();
        send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0); drain();
        send(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 0); drain();
        send(32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0); drain();

        // Backpressure
        out_ready = 1'b0;
        send(32'h0000_0010, 32'h0000_0008, 32'h0000_0020, 0);
        for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
        ps = 32'hCAFE_0000; sc = 32'h0000_1111; cur_exp = 32'hDEAD_DEAD; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_sum", sum, 32'h0000_0020);
            chk("bp_in_ready", W'(in_ready), W'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_single_hs", W'(out_valid), W'(0));
        drain();

        // Back-to-back with in_valid held
        send(32'h1111_1111, 32'h2222_2222, 32'h5555_5555, 1);
        a0 = last_acc;
        send(32'h0F0F_0F0F, 32'h0808_0808, 32'h1F1F_1F1F, 1);
        a1 = last_acc;
        chk("b2b_spacing1", W'(a1 - a0), W'(5));
        send(32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEF1, 0);
        chk("b2b_spacing2", W'(last_acc - a1), W'(5));
        drain();

        // Reset in the middle of ADD
        send(32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5554, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_sum", sum, '0);
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        exp_q.delete(); acc_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h1234_5678, 32'h0000_0001, 32'h1234_567A, 0); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_csa_resolver

`default_nettype wire
